alu_acc_sequencer: RTL and testbench

- Accumulator/flag sequencer that sits directly around the ALU's 8-bit full adder.
- Upstream role: drives the adder's A, B and carry-in operands.
- Downstream role: consumes the adder's sum and carry-out, then registers the result into the accumulator and Z/N/C/V flags.
- Accepts one operation at a time over a valid/ready handshake; multiply runs as an 8-step shift-add loop through the same adder.

---
 rtl/alu_acc_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_alu_acc_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_acc_sequencer.sv
// Accumulator/flag sequencer wrapped around an external 8-bit full adder.
// Runs single-cycle arithmetic ops and an 8-step shift-add multiply through the same adder.
module alu_acc_sequencer #(
  parameter bit MUL_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_op,
  input  logic [7:0] in_operand,
  output logic [7:0] adder_a,
  output logic [7:0] adder_b,
  output logic       adder_cin,
  input  logic [7:0] adder_sum,
  input  logic       adder_cout,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] result,
  output logic       flag_c,
  output logic       flag_z,
  output logic       flag_n,
  output logic       flag_v,
  output logic       err,
  output logic [1:0] dbg_state
);

  // Handshakes: an op transfers on the rising edge where in_valid & in_ready;
  // out_valid then holds until the rising edge where out_valid & out_ready.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_ADC  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_SBC  = 3'd4;
  localparam logic [2:0] OP_MUL  = 3'd5;
  localparam logic [2:0] OP_CMP  = 3'd6;

  state_t      state, state_next;
  logic [2:0]  op_q;
  logic [7:0]  operand_q;
  logic [7:0]  acc;
  logic [7:0]  mul_hi, mul_lo, mcand;
  logic [2:0]  mul_count;
  logic [7:0]  mul_hi_next, mul_lo_next;
  logic        arith_v;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign result    = acc;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (in_valid) state_next = (in_op == OP_MUL && MUL_EN) ? S_MUL : S_EXEC;
      S_EXEC: state_next = S_DONE;
      S_MUL:  if (mul_count == 3'd7) state_next = S_DONE;
      S_DONE: if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Subtraction is a + ~b + cin, so C=1 means no borrow.
  always_comb begin
    adder_a   = 8'h00;
    adder_b   = 8'h00;
    adder_cin = 1'b0;
    if (state == S_EXEC) begin
      case (op_q)
        OP_ADD: begin
          adder_a = acc;
          adder_b = operand_q;
        end
        OP_ADC: begin
          adder_a   = acc;
          adder_b   = operand_q;
          adder_cin = flag_c;
        end
        OP_SUB, OP_CMP: begin
          adder_a   = acc;
          adder_b   = ~operand_q;
          adder_cin = 1'b1;
        end
        OP_SBC: begin
          adder_a   = acc;
          adder_b   = ~operand_q;
          adder_cin = flag_c;
        end
        default: ;
      endcase
    end else if (state == S_MUL) begin
      adder_a = mul_hi;
      adder_b = mul_lo[0] ? mcand : 8'h00;
    end
  end

  assign arith_v     = (adder_a[7] == adder_b[7]) & (adder_sum[7] != adder_a[7]);
  assign mul_hi_next = {adder_cout, adder_sum[7:1]};
  assign mul_lo_next = {adder_sum[0], mul_lo[7:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= 3'd0;
      operand_q <= 8'h00;
      acc       <= 8'h00;
      flag_c    <= 1'b0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_v    <= 1'b0;
      err       <= 1'b0;
      mul_hi    <= 8'h00;
      mul_lo    <= 8'h00;
      mcand     <= 8'h00;
      mul_count <= 3'd0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          op_q      <= in_op;
          operand_q <= in_operand;
          mul_hi    <= 8'h00;
          mul_lo    <= in_operand;
          mcand     <= acc;
          mul_count <= 3'd0;
        end
        S_EXEC: begin
          err <= 1'b0;
          case (op_q)
            OP_LOAD: begin
              acc    <= operand_q;
              flag_z <= (operand_q == 8'h00);
              flag_n <= operand_q[7];
              flag_v <= 1'b0;
            end
            OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
              acc    <= adder_sum;
              flag_c <= adder_cout;
              flag_z <= (adder_sum == 8'h00);
              flag_n <= adder_sum[7];
              flag_v <= arith_v;
            end
            OP_CMP: begin
              flag_c <= adder_cout;
              flag_z <= (adder_sum == 8'h00);
              flag_n <= adder_sum[7];
              flag_v <= arith_v;
            end
            // 111, or MUL when the multiplier is disabled
            default: err <= 1'b1;
          endcase
        end
        S_MUL: begin
          mul_hi    <= mul_hi_next;
          mul_lo    <= mul_lo_next;
          mul_count <= mul_count + 3'd1;
          if (mul_count == 3'd7) begin
            acc    <= mul_lo_next;
            flag_c <= (mul_hi_next != 8'h00);
            flag_z <= (mul_lo_next == 8'h00);
            flag_n <= mul_lo_next[7];
            flag_v <= 1'b0;
            err    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_acc_sequencer.sv
// Bench for alu_acc_sequencer: external adder model, directed and random ops,
// completions scoreboarded against an arithmetic reference model.
module tb_alu_acc_sequencer;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic [7:0] in_operand;
  logic [7:0] adder_a, adder_b, adder_sum;
  logic       adder_cin, adder_cout;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       flag_c, flag_z, flag_n, flag_v, err;
  logic [1:0] dbg_state;

  int compared;
  int mismatched;

  // {err, v, n, z, c, result}
  logic [12:0] exp_q[$];

  logic [7:0] m_acc;
  logic       m_c, m_z, m_n, m_v, m_err;

  alu_acc_sequencer #(.MUL_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_operand(in_operand),
    .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
    .adder_sum(adder_sum), .adder_cout(adder_cout),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
    .err(err), .dbg_state(dbg_state)
  );

  assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {8'h00, adder_cin};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_acc = 8'h00;
    m_c = 1'b0; m_z = 1'b0; m_n = 1'b0; m_v = 1'b0; m_err = 1'b0;
  endtask

  // Reference model: plain integer arithmetic on the architectural state.
  task automatic model_step(input logic [2:0] op, input logic [7:0] b, output logic [12:0] exp);
    int a, bb, cin, s, sa, sb, sr, p;
    case (op)
      3'd0: begin
        m_acc = b; m_z = (b == 0); m_n = (b >= 128); m_v = 1'b0; m_err = 1'b0;
      end
      3'd1, 3'd2, 3'd3, 3'd4, 3'd6: begin
        a   = int'(m_acc);
        bb  = (op == 3'd1 || op == 3'd2) ? int'(b) : 255 - int'(b);
        cin = (op == 3'd1) ? 0 : (op == 3'd3 || op == 3'd6) ? 1 : int'(m_c);
        s   = a + bb + cin;
        sa  = (a  >= 128) ? a  - 256 : a;
        sb  = (bb >= 128) ? bb - 256 : bb;
        sr  = sa + sb + cin;
        m_c = (s > 255);
        m_z = ((s % 256) == 0);
        m_n = ((s % 256) >= 128);
        m_v = (sr > 127) || (sr < -128);
        if (op != 3'd6) m_acc = 8'(s % 256);
        m_err = 1'b0;
      end
      3'd5: begin
        p = int'(m_acc) * int'(b);
        m_acc = 8'(p % 256);
        m_c = (p > 255); m_z = (m_acc == 0); m_n = (m_acc >= 128); m_v = 1'b0; m_err = 1'b0;
      end
      default: m_err = 1'b1;
    endcase
    exp = {m_err, m_v, m_n, m_z, m_c, m_acc};
  endtask

  // driver: issue one op, then hold off out_ready for bp cycles
  task automatic do_op(input logic [2:0] op, input logic [7:0] opnd, input int bp);
    logic [12:0] exp;
    logic [7:0]  ea, eb;
    logic        ec;
    int          edges;
    ea = 8'h00; eb = 8'h00; ec = 1'b0;
    case (op)
      3'd1: begin ea = m_acc; eb = opnd; end
      3'd2: begin ea = m_acc; eb = opnd; ec = m_c; end
      3'd3, 3'd6: begin ea = m_acc; eb = ~opnd; ec = 1'b1; end
      3'd4: begin ea = m_acc; eb = ~opnd; ec = m_c; end
      3'd5: begin ea = 8'h00; eb = opnd[0] ? m_acc : 8'h00; end
      default: ;
    endcase
    check("in_ready_idle", 16'(in_ready), 16'd1);
    in_valid = 1'b1; in_op = op; in_operand = opnd;
    @(posedge clk); #1;
    model_step(op, opnd, exp);
    exp_q.push_back(exp);
    in_valid = 1'($urandom_range(0, 1)); in_op = 3'($urandom_range(0, 7)); in_operand = 8'($urandom);
    check("adder_a", 16'(adder_a), 16'(ea));
    check("adder_b", 16'(adder_b), 16'(eb));
    check("adder_cin", 16'(adder_cin), 16'(ec));
    edges = 1;
    while (!out_valid && edges < 20) begin
      @(posedge clk); #1;
      edges++;
      in_valid = 1'($urandom_range(0, 1)); in_op = 3'($urandom_range(0, 7)); in_operand = 8'($urandom);
    end
    check("latency", 16'(edges), (op == 3'd5) ? 16'd9 : 16'd2);
    for (int i = 0; i < bp; i++) begin
      check("hold_valid", 16'(out_valid), 16'd1);
      check("hold_result", 16'(result), 16'(exp[7:0]));
      check("hold_in_ready", 16'(in_ready), 16'd0);
      in_valid = 1'($urandom_range(0, 1)); in_op = 3'($urandom_range(0, 7)); in_operand = 8'($urandom);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    check("released", 16'(out_valid), 16'd0);
  endtask

  // driver: start an op and hit rst asynchronously after n more edges
  task automatic abort_op(input logic [2:0] op, input logic [7:0] opnd, input int n);
    in_valid = 1'b1; in_op = op; in_operand = opnd;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    model_reset();
    check("abort_in_ready", 16'(in_ready), 16'd1);
    check("abort_out_valid", 16'(out_valid), 16'd0);
    check("abort_result", 16'(result), 16'(m_acc));
    check("abort_flags", 16'({err, flag_v, flag_n, flag_z, flag_c}), 16'd0);
    @(negedge clk); rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("abort_no_completion", 16'(out_valid), 16'd0);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [12:0] exp;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_completion", 16'(out_valid), 16'd0);
      end else begin
        exp = exp_q.pop_front();
        check("result", 16'(result), 16'(exp[7:0]));
        check("flags_vnzc", 16'({flag_v, flag_n, flag_z, flag_c}), 16'(exp[11:8]));
        check("err", 16'(err), 16'(exp[12]));
      end
    end
  end

  // directed sequence
  logic [2:0] d_op[22]  = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd2, 3'd0, 3'd3, 3'd6, 3'd0, 3'd3, 3'd4,
                            3'd0, 3'd5, 3'd0, 3'd5, 3'd0, 3'd7, 3'd0, 3'd5, 3'd2, 3'd4, 3'd6};
  logic [7:0] d_opnd[22] = '{8'h7F, 8'h01, 8'hFF, 8'h01, 8'h00, 8'h05, 8'h07, 8'hFE, 8'h05, 8'h07, 8'h00,
                             8'h0D, 8'h0B, 8'h10, 8'h20, 8'h81, 8'h3C, 8'hFF, 8'hFF, 8'h80, 8'h7F, 8'h81};

  initial begin
    compared = 0; mismatched = 0;
    model_reset();
    rst = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_operand = 8'h00; out_ready = 1'b0;
    #3;
    check("reset_in_ready", 16'(in_ready), 16'd1);
    check("reset_out_valid", 16'(out_valid), 16'd0);
    check("reset_result", 16'(result), 16'd0);
    check("reset_flags", 16'({err, flag_v, flag_n, flag_z, flag_c}), 16'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 22; i++) do_op(d_op[i], d_opnd[i], (i == 1) ? 5 : 0);

    do_op(3'd0, 8'h55, 0);
    abort_op(3'd5, 8'h03, 3);
    do_op(3'd0, 8'hA7, 0);
    abort_op(3'd0, 8'h42, 1);

    for (int i = 0; i < 60; i++)
      do_op(3'($urandom_range(0, 7)), 8'($urandom), $urandom_range(0, 3));

    repeat (2) @(posedge clk);
    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
